// File: rtl/decode_issue.sv
// Decode/issue stage: decodes 16-bit instructions into a one-entry issue register, owns the
// N/Z/V flags and resolves B/BR/HLT. Define DECODE_FLAG_FWD_EN to let branches see same-cycle flag returns.
module decode_issue #(
    parameter logic [2:0]  RESET_FLAGS = 3'b000,
    parameter logic [15:0] PC_INC      = 16'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Inst_Valid,
    output logic        Inst_Ready,
    input  logic [15:0] Inst,
    input  logic [15:0] Inst_PC,
    output logic [3:0]  RF_SrcReg1,
    output logic [3:0]  RF_SrcReg2,
    input  logic [15:0] RF_Data1,
    input  logic [15:0] RF_Data2,
    output logic        Iss_Valid,
    input  logic        Iss_Ready,
    output logic [3:0]  Opcode,
    output logic [15:0] ALU_In1,
    output logic [15:0] ALU_In2,
    output logic [3:0]  Iss_DstReg,
    output logic        Iss_WrEn,
    output logic [15:0] Iss_StoreData,
    input  logic        Ex_FlagValid,
    input  logic [3:0]  Ex_Opcode,
    input  logic        N_Flag,
    input  logic        Z_Flag,
    input  logic        V_Flag,
    output logic [2:0]  Flags,
    output logic        Br_Taken,
    output logic [15:0] Br_Target,
    output logic        Halted
);
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_SLL = 4'h4,
                           OP_SRA = 4'h5, OP_ROR = 4'h6, OP_LW  = 4'h8, OP_SW  = 4'h9,
                           OP_LLB = 4'hA, OP_LHB = 4'hB, OP_B   = 4'hC, OP_BR  = 4'hD,
                           OP_PCS = 4'hE, OP_HLT = 4'hF;

    function automatic logic is_flag_writer(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRA, OP_ROR: is_flag_writer = 1'b1;
            default:                                        is_flag_writer = 1'b0;
        endcase
    endfunction

    // flags are {N,Z,V}
    function automatic logic br_cond(input logic [2:0] ccc, input logic [2:0] f);
        logic n, z, v;
        n = f[2];
        z = f[1];
        v = f[0];
        case (ccc)
            3'b000:  br_cond = !z;
            3'b001:  br_cond = z;
            3'b010:  br_cond = !z & !n;
            3'b011:  br_cond = n;
            3'b100:  br_cond = z | (!z & !n);
            3'b101:  br_cond = n | z;
            3'b110:  br_cond = v;
            3'b111:  br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    endfunction

    logic        iss_valid_q, iss_valid_d;
    logic [3:0]  opcode_q, opcode_d, dst_q, dst_d;
    logic [15:0] in1_q, in1_d, in2_q, in2_d, store_q, store_d;
    logic        wren_q, wren_d;
    logic [2:0]  flags_q, flags_d, flags_upd_s, br_flags_s;
    logic        br_taken_q, br_taken_d, halted_q, halted_d;
    logic [15:0] br_target_q, br_target_d;
    logic [3:0]  op_s;
    logic [15:0] pc_inc_s, br_off_s, mem_off_s;
    logic        is_branch_s, issues_s, stall_ex_s, br_stall_s, accept_s, live_s;

    // Decode, readiness, flag update and next-state for all registers
    always_comb begin
        op_s        = Inst[15:12];
        pc_inc_s    = Inst_PC + PC_INC;
        br_off_s    = {{6{Inst[8]}}, Inst[8:0], 1'b0};
        mem_off_s   = {{11{Inst[3]}}, Inst[3:0], 1'b0};
        is_branch_s = (op_s == OP_B) || (op_s == OP_BR);
        issues_s    = !is_branch_s && (op_s != OP_HLT);

        RF_SrcReg1 = Inst[7:4];
        RF_SrcReg2 = Inst[3:0];
        case (op_s)
            OP_SW:          RF_SrcReg2 = Inst[11:8];
            OP_LLB, OP_LHB: RF_SrcReg1 = Inst[11:8];
            default:        RF_SrcReg1 = Inst[7:4];
        endcase

        flags_upd_s = flags_q;
        if (Ex_FlagValid) begin
            case (Ex_Opcode)
                OP_ADD, OP_SUB:                 flags_upd_s = {N_Flag, Z_Flag, V_Flag};
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_upd_s[1] = Z_Flag;
                default:                        flags_upd_s = flags_q;
            endcase
        end else begin
            flags_upd_s = flags_q;
        end

`ifdef DECODE_FLAG_FWD_EN
        br_flags_s = flags_upd_s;
        stall_ex_s = 1'b0;
`else
        br_flags_s = flags_q;
        stall_ex_s = Ex_FlagValid;
`endif
        br_stall_s = is_branch_s && ((iss_valid_q && is_flag_writer(opcode_q)) || stall_ex_s);
        Inst_Ready = !halted_q && (!iss_valid_q || Iss_Ready) && !br_stall_s;
        accept_s   = Inst_Valid && Inst_Ready;
        // anything accepted in the redirect cycle is on the wrong path
        live_s     = accept_s && !br_taken_q;

        iss_valid_d = iss_valid_q && !Iss_Ready;
        opcode_d    = opcode_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        dst_d       = dst_q;
        wren_d      = wren_q;
        store_d     = store_q;
        if (live_s && issues_s) begin
            iss_valid_d = 1'b1;
            opcode_d    = op_s;
            in1_d       = RF_Data1;
            in2_d       = RF_Data2;
            dst_d       = Inst[11:8];
            wren_d      = 1'b1;
            store_d     = 16'h0000;
            case (op_s)
                OP_LW:          in2_d = mem_off_s;
                OP_SW: begin
                    in2_d   = mem_off_s;
                    wren_d  = 1'b0;
                    store_d = RF_Data2;
                end
                OP_LLB, OP_LHB: in2_d = {8'h00, Inst[7:0]};
                OP_PCS: begin
                    in1_d = pc_inc_s;
                    in2_d = 16'h0000;
                end
                default:        in2_d = RF_Data2;
            endcase
        end else begin
            opcode_d = opcode_q;
        end

        br_taken_d  = live_s && is_branch_s && br_cond(Inst[11:9], br_flags_s);
        if (br_taken_d) begin
            br_target_d = (op_s == OP_B) ? (pc_inc_s + br_off_s) : RF_Data1;
        end else begin
            br_target_d = br_target_q;
        end
        halted_d = halted_q || (live_s && (op_s == OP_HLT));
        flags_d  = flags_upd_s;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_q <= 1'b0;
            opcode_q    <= 4'h0;
            in1_q       <= 16'h0000;
            in2_q       <= 16'h0000;
            dst_q       <= 4'h0;
            wren_q      <= 1'b0;
            store_q     <= 16'h0000;
            flags_q     <= RESET_FLAGS;
            br_taken_q  <= 1'b0;
            br_target_q <= 16'h0000;
            halted_q    <= 1'b0;
        end else begin
            iss_valid_q <= iss_valid_d;
            opcode_q    <= opcode_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            dst_q       <= dst_d;
            wren_q      <= wren_d;
            store_q     <= store_d;
            flags_q     <= flags_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
            halted_q    <= halted_d;
        end
    end

    assign Iss_Valid     = iss_valid_q;
    assign Opcode        = opcode_q;
    assign ALU_In1       = in1_q;
    assign ALU_In2       = in2_q;
    assign Iss_DstReg    = dst_q;
    assign Iss_WrEn      = wren_q;
    assign Iss_StoreData = store_q;
    assign Flags         = flags_q;
    assign Br_Taken      = br_taken_q;
    assign Br_Target     = br_target_q;
    assign Halted        = halted_q;
endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue; expectations follow DECODE_FLAG_FWD_EN when it is defined.
module tb_decode_issue;
    logic        clk = 1'b0;
    logic        rst, Inst_Valid, Inst_Ready, Iss_Valid, Iss_Ready, Iss_WrEn;
    logic [15:0] Inst, Inst_PC, RF_Data1, RF_Data2, ALU_In1, ALU_In2, Iss_StoreData, Br_Target;
    logic [3:0]  RF_SrcReg1, RF_SrcReg2, Opcode, Iss_DstReg, Ex_Opcode;
    logic        Ex_FlagValid, N_Flag, Z_Flag, V_Flag, Br_Taken, Halted;
    logic [2:0]  Flags;
    logic [15:0] rf [16];
    int errors = 0;
    int checks = 0;

    decode_issue dut (
        .clk(clk), .rst(rst), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready), .Inst(Inst),
        .Inst_PC(Inst_PC), .RF_SrcReg1(RF_SrcReg1), .RF_SrcReg2(RF_SrcReg2), .RF_Data1(RF_Data1),
        .RF_Data2(RF_Data2), .Iss_Valid(Iss_Valid), .Iss_Ready(Iss_Ready), .Opcode(Opcode),
        .ALU_In1(ALU_In1), .ALU_In2(ALU_In2), .Iss_DstReg(Iss_DstReg), .Iss_WrEn(Iss_WrEn),
        .Iss_StoreData(Iss_StoreData), .Ex_FlagValid(Ex_FlagValid), .Ex_Opcode(Ex_Opcode),
        .N_Flag(N_Flag), .Z_Flag(Z_Flag), .V_Flag(V_Flag), .Flags(Flags), .Br_Taken(Br_Taken),
        .Br_Target(Br_Target), .Halted(Halted)
    );

    always #5 clk = ~clk;
    assign RF_Data1 = rf[RF_SrcReg1];
    assign RF_Data2 = rf[RF_SrcReg2];

    task automatic drive(input logic v, input logic [15:0] inst, input logic [15:0] pc);
        Inst_Valid = v;
        Inst       = inst;
        Inst_PC    = pc;
    endtask

    task automatic flag_ret(input logic v, input logic [3:0] op, input logic [2:0] nzv);
        Ex_FlagValid = v;
        Ex_Opcode    = op;
        {N_Flag, Z_Flag, V_Flag} = nzv;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (Iss_Valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", Iss_Valid); end
        checks++; if (Flags !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", Flags); end
        checks++; if ({Br_Taken, Br_Target, Halted} !== 18'h0) begin errors++; $display("FAIL rst_br_halt got=%b/%h/%b exp=0/0000/0", Br_Taken, Br_Target, Halted); end
        checks++; if ({Opcode, ALU_In1, ALU_In2, Iss_DstReg, Iss_WrEn} !== 41'h0) begin errors++; $display("FAIL rst_issue got=%h/%h/%h exp=0/0/0", Opcode, ALU_In1, ALU_In2); end
        checks++; if (Inst_Ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", Inst_Ready); end
        rst = 1'b0;
    endtask

    task automatic test_add;
        Iss_Ready = 1'b1;
        drive(1'b1, 16'h0312, 16'h0000);
        #1;
        checks++; if ({RF_SrcReg1, RF_SrcReg2} !== 8'h12) begin errors++; $display("FAIL add_srcregs got=%h exp=12", {RF_SrcReg1, RF_SrcReg2}); end
        @(negedge clk);
        drive(1'b0, 16'h0000, 16'h0000);
        #1;
        checks++; if (Iss_Valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", Iss_Valid); end
        checks++; if ({Opcode, ALU_In1, ALU_In2, Iss_DstReg, Iss_WrEn} !== {4'h0, 16'd5, 16'd7, 4'h3, 1'b1}) begin errors++; $display("FAIL add_fields got=%h/%h/%h/%h/%b exp=0/5/7/3/1", Opcode, ALU_In1, ALU_In2, Iss_DstReg, Iss_WrEn); end
        @(negedge clk);
        #1;
        checks++; if (Iss_Valid !== 1'b0) begin errors++; $display("FAIL add_drain got=%b exp=0", Iss_Valid); end
    endtask

    task automatic test_backpressure;
        Iss_Ready = 1'b0;
        drive(1'b1, 16'h2412, 16'h0000);
        @(negedge clk);
        drive(1'b1, 16'h1521, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (Inst_Ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, Inst_Ready); end
            checks++; if ({Iss_Valid, Opcode, ALU_In1, Iss_DstReg} !== {1'b1, 4'h2, 16'd5, 4'h4}) begin errors++; $display("FAIL bp_hold[%0d] got=%b/%h/%h/%h exp=1/2/5/4", i, Iss_Valid, Opcode, ALU_In1, Iss_DstReg); end
            @(negedge clk);
        end
        Iss_Ready = 1'b1;
        #1;
        checks++; if (Inst_Ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", Inst_Ready); end
        @(negedge clk);
        drive(1'b0, 16'h0000, 16'h0000);
        #1;
        checks++; if ({Iss_Valid, Opcode, ALU_In1, ALU_In2, Iss_DstReg} !== {1'b1, 4'h1, 16'd7, 16'd5, 4'h5}) begin errors++; $display("FAIL bp_sub got=%b/%h/%h/%h/%h exp=1/1/7/5/5", Iss_Valid, Opcode, ALU_In1, ALU_In2, Iss_DstReg); end
        @(negedge clk);
    endtask

    task automatic test_mem_imm;
        Iss_Ready = 1'b1;
        drive(1'b1, 16'h8613, 16'h0000);
        @(negedge clk);
        drive(1'b1, 16'h921F, 16'h0000);
        #1;
        checks++; if ({Opcode, ALU_In1, ALU_In2, Iss_DstReg, Iss_WrEn} !== {4'h8, 16'd5, 16'd6, 4'h6, 1'b1}) begin errors++; $display("FAIL lw got=%h/%h/%h/%h/%b exp=8/5/6/6/1", Opcode, ALU_In1, ALU_In2, Iss_DstReg, Iss_WrEn); end
        @(negedge clk);
        drive(1'b1, 16'hA7AB, 16'h0000);
        #1;
        checks++; if ({Iss_Valid, Opcode, ALU_In1, ALU_In2, Iss_WrEn, Iss_StoreData} !== {1'b1, 4'h9, 16'd5, 16'hFFFE, 1'b0, 16'd7}) begin errors++; $display("FAIL sw got=%h/%h/%h/%b/%h exp=9/5/fffe/0/7", Opcode, ALU_In1, ALU_In2, Iss_WrEn, Iss_StoreData); end
        @(negedge clk);
        drive(1'b1, 16'hE800, 16'h0100);
        #1;
        checks++; if ({Opcode, ALU_In1, ALU_In2, Iss_DstReg, Iss_WrEn} !== {4'hA, 16'h7777, 16'h00AB, 4'h7, 1'b1}) begin errors++; $display("FAIL llb got=%h/%h/%h/%h/%b exp=a/7777/00ab/7/1", Opcode, ALU_In1, ALU_In2, Iss_DstReg, Iss_WrEn); end
        @(negedge clk);
        drive(1'b0, 16'h0000, 16'h0000);
        #1;
        checks++; if ({Iss_Valid, Opcode, ALU_In1, ALU_In2, Iss_DstReg} !== {1'b1, 4'hE, 16'h0102, 16'h0000, 4'h8}) begin errors++; $display("FAIL pcs got=%b/%h/%h/%h/%h exp=1/e/0102/0000/8", Iss_Valid, Opcode, ALU_In1, ALU_In2, Iss_DstReg); end
        @(negedge clk);
    endtask

    task automatic test_flags;
        flag_ret(1'b1, 4'h2, 3'b111);
        @(negedge clk);
        #1;
        checks++; if (Flags !== 3'b010) begin errors++; $display("FAIL flags_xor got=%b exp=010", Flags); end
        flag_ret(1'b1, 4'h0, 3'b111);
        @(negedge clk);
        #1;
        checks++; if (Flags !== 3'b111) begin errors++; $display("FAIL flags_add got=%b exp=111", Flags); end
        flag_ret(1'b1, 4'h8, 3'b000);
        @(negedge clk);
        #1;
        checks++; if (Flags !== 3'b111) begin errors++; $display("FAIL flags_lw got=%b exp=111", Flags); end
        flag_ret(1'b1, 4'h1, 3'b010);
        @(negedge clk);
        flag_ret(1'b0, 4'h0, 3'b000);
        #1;
        checks++; if (Flags !== 3'b010) begin errors++; $display("FAIL flags_sub got=%b exp=010", Flags); end
    endtask

    task automatic test_branch;
        Iss_Ready = 1'b1;
        drive(1'b1, 16'hC3FE, 16'h0010);
        @(negedge clk);
        drive(1'b1, 16'h0312, 16'h0000);
        #1;
        checks++; if ({Br_Taken, Br_Target} !== {1'b1, 16'h000E}) begin errors++; $display("FAIL b_taken got=%b/%h exp=1/000e", Br_Taken, Br_Target); end
        checks++; if ({Inst_Ready, Iss_Valid} !== 2'b10) begin errors++; $display("FAIL b_pulse_cycle got=%b exp=10", {Inst_Ready, Iss_Valid}); end
        @(negedge clk);
        drive(1'b1, 16'hC1FE, 16'h0030);
        #1;
        checks++; if ({Br_Taken, Iss_Valid} !== 2'b00) begin errors++; $display("FAIL b_squash got=%b exp=00", {Br_Taken, Iss_Valid}); end
        @(negedge clk);
        drive(1'b1, 16'hDE40, 16'h0040);
        #1;
        checks++; if (Br_Taken !== 1'b0) begin errors++; $display("FAIL b_not_taken got=%b exp=0", Br_Taken); end
        @(negedge clk);
        drive(1'b0, 16'h0000, 16'h0000);
        #1;
        checks++; if ({Br_Taken, Br_Target} !== {1'b1, 16'h0040}) begin errors++; $display("FAIL br_always got=%b/%h exp=1/0040", Br_Taken, Br_Target); end
        @(negedge clk);
        #1;
        checks++; if (Br_Taken !== 1'b0) begin errors++; $display("FAIL br_one_pulse got=%b exp=0", Br_Taken); end
    endtask

    task automatic test_br_stall;
        Iss_Ready = 1'b0;
        drive(1'b1, 16'h0312, 16'h0000);
        @(negedge clk);
        drive(1'b1, 16'hCE00, 16'h0020);
        #1;
        checks++; if (Inst_Ready !== 1'b0) begin errors++; $display("FAIL stall_held got=%b exp=0", Inst_Ready); end
        @(negedge clk);
        Iss_Ready = 1'b1;
        #1;
        checks++; if (Inst_Ready !== 1'b0) begin errors++; $display("FAIL stall_consume got=%b exp=0", Inst_Ready); end
        @(negedge clk);
        #1;
        checks++; if ({Iss_Valid, Inst_Ready} !== 2'b01) begin errors++; $display("FAIL stall_clear got=%b exp=01", {Iss_Valid, Inst_Ready}); end
        @(negedge clk);
        drive(1'b0, 16'h0000, 16'h0000);
        #1;
        checks++; if ({Br_Taken, Br_Target} !== {1'b1, 16'h0022}) begin errors++; $display("FAIL stall_branch got=%b/%h exp=1/0022", Br_Taken, Br_Target); end
        @(negedge clk);
        drive(1'b1, 16'hD040, 16'h0000);
        flag_ret(1'b1, 4'h0, 3'b000);
        #1;
`ifdef DECODE_FLAG_FWD_EN
        checks++; if (Inst_Ready !== 1'b1) begin errors++; $display("FAIL fwd_ready got=%b exp=1", Inst_Ready); end
        @(negedge clk);
        drive(1'b0, 16'h0000, 16'h0000);
        flag_ret(1'b0, 4'h0, 3'b000);
`else
        checks++; if (Inst_Ready !== 1'b0) begin errors++; $display("FAIL nofwd_stall got=%b exp=0", Inst_Ready); end
        @(negedge clk);
        flag_ret(1'b0, 4'h0, 3'b000);
        #1;
        checks++; if ({Inst_Ready, Flags} !== 4'b1000) begin errors++; $display("FAIL nofwd_ready got=%b/%b exp=1/000", Inst_Ready, Flags); end
        @(negedge clk);
        drive(1'b0, 16'h0000, 16'h0000);
`endif
        #1;
        checks++; if ({Br_Taken, Br_Target} !== {1'b1, 16'h0040}) begin errors++; $display("FAIL flagret_br got=%b/%h exp=1/0040", Br_Taken, Br_Target); end
        @(negedge clk);
    endtask

    task automatic test_halt;
        Iss_Ready = 1'b1;
        drive(1'b1, 16'hF000, 16'h0000);
        flag_ret(1'b1, 4'h1, 3'b101);
        @(negedge clk);
        flag_ret(1'b0, 4'h0, 3'b000);
        drive(1'b1, 16'h0312, 16'h0000);
        #1;
        checks++; if ({Halted, Flags, Inst_Ready} !== 5'b1_101_0) begin errors++; $display("FAIL halt got=%b/%b/%b exp=1/101/0", Halted, Flags, Inst_Ready); end
        @(negedge clk);
        #1;
        checks++; if ({Halted, Iss_Valid} !== 2'b10) begin errors++; $display("FAIL halt_sticky got=%b exp=10", {Halted, Iss_Valid}); end
        drive(1'b0, 16'h0000, 16'h0000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if ({Halted, Flags, Inst_Ready} !== 5'b0_000_1) begin errors++; $display("FAIL halt_rst got=%b/%b/%b exp=0/000/1", Halted, Flags, Inst_Ready); end
    endtask

    task automatic test_reset_mid;
        Iss_Ready = 1'b0;
        drive(1'b1, 16'h921F, 16'h0000);
        flag_ret(1'b1, 4'h0, 3'b111);
        @(negedge clk);
        flag_ret(1'b0, 4'h0, 3'b000);
        #1;
        checks++; if ({Iss_Valid, Flags, Iss_StoreData} !== {1'b1, 3'b111, 16'd7}) begin errors++; $display("FAIL mid_setup got=%b/%b/%h exp=1/111/0007", Iss_Valid, Flags, Iss_StoreData); end
        Iss_Ready = 1'b1;
        drive(1'b1, 16'hCE00, 16'h0040);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000);
        #1;
        checks++; if ({Iss_Valid, Opcode, ALU_In1, ALU_In2, Iss_DstReg, Iss_WrEn, Iss_StoreData} !== 58'h0) begin errors++; $display("FAIL mid_issue got=%b/%h/%h/%h/%h/%b/%h exp=all 0", Iss_Valid, Opcode, ALU_In1, ALU_In2, Iss_DstReg, Iss_WrEn, Iss_StoreData); end
        checks++; if ({Flags, Br_Taken, Br_Target, Halted} !== 21'h0) begin errors++; $display("FAIL mid_br_flags got=%b/%b/%h/%b exp=000/0/0000/0", Flags, Br_Taken, Br_Target, Halted); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 16'h1000 + 16'(i);
        rf[1] = 16'd5;
        rf[2] = 16'd7;
        rf[4] = 16'h0040;
        rf[7] = 16'h7777;
        Iss_Ready = 1'b1;
        drive(1'b0, 16'h0000, 16'h0000);
        flag_ret(1'b0, 4'h0, 3'b000);
        test_reset();
        test_add();
        test_backpressure();
        test_mem_imm();
        test_flags();
        test_branch();
        test_br_stall();
        test_halt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
